// File: rtl/cursor_pkg.sv
// cursor_pkg: shared screen defaults, clamp-limit helpers, FSM states and arbitration priority
// for the crosshair cursor controller.
package cursor_pkg;
    localparam int H_RES_DEF   = 640;
    localparam int V_RES_DEF   = 480;
    localparam int ARM_DEF     = 8;
    localparam int COORD_W_DEF = 11;

    function automatic int lo_lim(input int arm);
        return arm / 2;
    endfunction

    function automatic int hi_lim(input int res, input int arm);
        return res - 1 - arm / 2;
    endfunction

    localparam int X_MIN = lo_lim(ARM_DEF);
    localparam int X_MAX = hi_lim(H_RES_DEF, ARM_DEF);
    localparam int Y_MIN = lo_lim(ARM_DEF);
    localparam int Y_MAX = hi_lim(V_RES_DEF, ARM_DEF);

    typedef enum logic [1:0] {IDLE, APPLY, CLAMP} state_t;
    typedef enum logic {PRI_KEY, PRI_MOUSE} pri_t;
endpackage

// File: rtl/cursor_step_timer.sv
// cursor_step_timer: free-running key step divider; raises step_pend on a wrap while any key is held
// and holds it until the controller grants the key requester.
module cursor_step_timer
    import cursor_pkg::*;
#(
    parameter int STEP_DIV = 500000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic any_key,
    input  logic clear,
    output logic step_pend
);
    localparam int CW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = cnt == CW'(STEP_DIV - 1);

    // A wrap in the same cycle as a grant re-arms the request rather than losing the step.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            cnt       <= '0;
            step_pend <= 1'b0;
        end else begin
            cnt       <= wrap ? '0 : cnt + CW'(1);
            step_pend <= (wrap && any_key) || (step_pend && !clear);
        end
    end
endmodule

// File: rtl/cursor_ctrl.sv
// cursor_ctrl: round-robin key/mouse movement, clamped to keep the crosshair on screen, committed at frame start.
// Define CURSOR_WRAP_EN to wrap across screen edges instead of saturating.
module cursor_ctrl
    import cursor_pkg::*;
#(
    parameter int H_RES    = H_RES_DEF,
    parameter int V_RES    = V_RES_DEF,
    parameter int ARM      = ARM_DEF,
    parameter int COORD_W  = COORD_W_DEF,
    parameter int STEP_DIV = 500000,
    parameter int KEY_STEP = 2
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               key_up,
    input  logic               key_down,
    input  logic               key_left,
    input  logic               key_right,
    input  logic               mouse_valid,
    input  logic [8:0]         mouse_dx,
    input  logic [8:0]         mouse_dy,
    output logic               mouse_ready,
    input  logic               frame_start,
    output logic [COORD_W-1:0] cursor_x,
    output logic [COORD_W-1:0] cursor_y,
    output logic               pos_update
);
    localparam logic signed [12:0] XL = 13'(lo_lim(ARM));
    localparam logic signed [12:0] XH = 13'(hi_lim(H_RES, ARM));
    localparam logic signed [12:0] YL = 13'(lo_lim(ARM));
    localparam logic signed [12:0] YH = 13'(hi_lim(V_RES, ARM));
    localparam logic signed [12:0] KS = 13'(KEY_STEP);
    localparam logic [COORD_W-1:0] X0 = COORD_W'(H_RES / 2);
    localparam logic [COORD_W-1:0] Y0 = COORD_W'(V_RES / 2);

    state_t state, state_nxt;
    pri_t   pri;
    logic   step_pend, key_grant, any_key, commit, commit_pend;
    logic signed [12:0] key_dx, key_dy, dx, dy, sum_x, sum_y;
    logic [COORD_W-1:0] work_x, work_y, clamp_x, clamp_y, new_x, new_y;

    assign any_key = key_up | key_down | key_left | key_right;
    assign key_dx  = (key_right ? KS : '0) - (key_left ? KS : '0);
    assign key_dy  = (key_down ? KS : '0) - (key_up ? KS : '0);

    cursor_step_timer #(.STEP_DIV(STEP_DIV)) u_timer (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .any_key   (any_key),
        .clear     (key_grant),
        .step_pend (step_pend)
    );

    always_ff @(posedge CLOCK_50) state <= !reset ? IDLE : state_nxt;

    always_comb begin
        state_nxt = state == IDLE ? ((key_grant || mouse_ready) ? APPLY : IDLE)
                  : state == APPLY ? CLAMP : IDLE;
    end

    // Grants are held off while reset is low so no transfer is acknowledged and then discarded.
    always_comb begin
        mouse_ready = reset && state == IDLE && mouse_valid && (!step_pend || pri == PRI_MOUSE);
        key_grant   = reset && state == IDLE && step_pend && (!mouse_valid || pri == PRI_KEY);
    end

    always_comb begin
`ifdef CURSOR_WRAP_EN
        clamp_x = COORD_W'(sum_x < XL ? XH : sum_x > XH ? XL : sum_x);
        clamp_y = COORD_W'(sum_y < YL ? YH : sum_y > YH ? YL : sum_y);
`else
        clamp_x = COORD_W'(sum_x < XL ? XL : sum_x > XH ? XH : sum_x);
        clamp_y = COORD_W'(sum_y < YL ? YL : sum_y > YH ? YH : sum_y);
`endif
        commit = (state == IDLE && frame_start) || (state == CLAMP && (commit_pend || frame_start));
        new_x  = state == CLAMP ? clamp_x : work_x;
        new_y  = state == CLAMP ? clamp_y : work_y;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            work_x      <= X0;
            work_y      <= Y0;
            cursor_x    <= X0;
            cursor_y    <= Y0;
            pri         <= PRI_KEY;
            commit_pend <= 1'b0;
            pos_update  <= 1'b0;
            dx          <= '0;
            dy          <= '0;
            sum_x       <= '0;
            sum_y       <= '0;
        end else begin
            pos_update  <= commit && (new_x != cursor_x || new_y != cursor_y);
            commit_pend <= state == APPLY && (commit_pend || frame_start);
            if (commit) begin
                cursor_x <= new_x;
                cursor_y <= new_y;
            end
            if (key_grant) begin
                dx  <= key_dx;
                dy  <= key_dy;
                pri <= PRI_MOUSE;
            end else if (mouse_ready) begin
                dx  <= {{4{mouse_dx[8]}}, mouse_dx};
                dy  <= {{4{mouse_dy[8]}}, mouse_dy};
                pri <= PRI_KEY;
            end
            if (state == APPLY) begin
                sum_x <= $signed(13'(work_x)) + dx;
                sum_y <= $signed(13'(work_y)) + dy;
            end
            if (state == CLAMP) begin
                work_x <= clamp_x;
                work_y <= clamp_y;
            end
        end
    end
endmodule

// File: tb/tb_cursor_ctrl.sv
// tb_cursor_ctrl: directed scenarios plus randomized traffic against a cycle-level behavioural model.
// Honours CURSOR_WRAP_EN for the edge behaviour.
module tb_cursor_ctrl;
    logic CLOCK_50 = 1'b0;
    logic reset = 1'b0;
    logic key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
    logic mouse_valid = 1'b0, frame_start = 1'b0;
    logic [8:0] mouse_dx = '0, mouse_dy = '0;
    logic mouse_ready, pos_update;
    logic [10:0] cursor_x, cursor_y;

    int n_cmp = 0, n_err = 0, n_pulse = 0, m_nkey = 0;
    int m_cnt, m_busy, m_dx, m_dy, m_wx, m_wy, m_cx, m_cy;
    bit m_pend, m_pri, m_cpend, m_upd, m_took, dut_took;

    always #5 CLOCK_50 = ~CLOCK_50;

    cursor_ctrl #(.STEP_DIV(4)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .mouse_valid(mouse_valid), .mouse_dx(mouse_dx), .mouse_dy(mouse_dy), .mouse_ready(mouse_ready),
        .frame_start(frame_start), .cursor_x(cursor_x), .cursor_y(cursor_y), .pos_update(pos_update)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int lim(input int v, input int lo, input int hi);
`ifdef CURSOR_WRAP_EN
        return v < lo ? hi : v > hi ? lo : v;
`else
        return v < lo ? lo : v > hi ? hi : v;
`endif
    endfunction

    // m_busy counts remaining service cycles: 2 = delta latched, 1 = sum ready, 0 = free
    function automatic bit m_ready();
        return reset && m_busy == 0 && mouse_valid && (!m_pend || m_pri);
    endfunction

    task automatic m_step();
        bit wrap, kg, mg, cm;
        int nx, ny;
        m_took = 0;
        if (!reset) begin
            m_cnt = 0; m_pend = 0; m_busy = 0; m_pri = 0; m_cpend = 0; m_upd = 0;
            m_wx = 320; m_wy = 240; m_cx = 320; m_cy = 240; m_dx = 0; m_dy = 0;
            return;
        end
        wrap = m_cnt == 3;
        mg = m_ready();
        kg = m_busy == 0 && m_pend && (!mouse_valid || !m_pri);
        cm = 0; nx = m_cx; ny = m_cy;
        if (m_busy == 1) begin
            m_wx = lim(m_wx + m_dx, 4, 635);
            m_wy = lim(m_wy + m_dy, 4, 475);
            cm = m_cpend || frame_start;
        end else if (m_busy == 0) cm = frame_start;
        if (cm) begin nx = m_wx; ny = m_wy; end
        m_upd = cm && (nx != m_cx || ny != m_cy);
        m_cx = nx; m_cy = ny;
        m_cpend = m_busy == 2 && (m_cpend || frame_start);
        m_busy = m_busy > 0 ? m_busy - 1 : (kg || mg) ? 2 : 0;
        if (kg) begin
            m_dx = 2 * (int'(key_right) - int'(key_left));
            m_dy = 2 * (int'(key_down) - int'(key_up));
            m_pri = 1; m_nkey++;
        end
        if (mg) begin
            m_dx = int'($signed(mouse_dx));
            m_dy = int'($signed(mouse_dy));
            m_pri = 0; m_took = 1;
        end
        m_pend = (wrap && (key_up || key_down || key_left || key_right)) || (m_pend && !kg);
        m_cnt = wrap ? 0 : m_cnt + 1;
    endtask

    task automatic cyc();
        #2;
        dut_took = mouse_ready === 1'b1 && mouse_valid;
        chk("mouse_ready", 32'(mouse_ready), 32'(m_ready()));
        @(posedge CLOCK_50);
        m_step();
        #1;
        chk("cursor_x", 32'(cursor_x), m_cx);
        chk("cursor_y", 32'(cursor_y), m_cy);
        chk("pos_update", 32'(pos_update), 32'(m_upd));
        if (pos_update === 1'b1) n_pulse++;
    endtask

    task automatic send(input int x, input int y, output int waited);
        mouse_valid = 1; mouse_dx = 9'(x); mouse_dy = 9'(y);
        waited = 0;
        for (int g = 1; g <= 30; g++) begin
            cyc();
            if (dut_took) begin waited = g; break; end
        end
        chk("send_handshake", 32'(waited != 0), 1);
        mouse_valid = 0;
    endtask

    task automatic do_reset();
        reset = 0; repeat (2) cyc(); reset = 1;
    endtask

    task automatic commit_now();
        frame_start = 1; cyc(); frame_start = 0;
    endtask

    initial begin
        int w;
        repeat (3) cyc();
        reset = 1;
        // 1: reset values reach the outputs unchanged
        n_pulse = 0;
        repeat (2) cyc();
        commit_now();
        chk("t1_x", 32'(cursor_x), 320);
        chk("t1_y", 32'(cursor_y), 240);
        cyc();
        chk("t1_pulses", n_pulse, 0);
        // 2: three key steps to the right
        n_pulse = 0; m_nkey = 0; key_right = 1;
        for (int g = 0; g < 60 && m_nkey < 3; g++) cyc();
        key_right = 0;
        repeat (8) cyc();
        commit_now();
        chk("t2_x", 32'(cursor_x), 326);
        chk("t2_y", 32'(cursor_y), 240);
        chk("t2_pulse", 32'(pos_update), 1);
        cyc();
        chk("t2_pulses", n_pulse, 1);
        // 3: two large deltas overshoot the left and bottom edges
        do_reset();
        send(-200, 150, w);
        send(-200, 150, w);
        repeat (3) cyc();
        commit_now();
`ifdef CURSOR_WRAP_EN
        chk("t3_x", 32'(cursor_x), 635);
        chk("t3_y", 32'(cursor_y), 4);
`else
        chk("t3_x", 32'(cursor_x), 4);
        chk("t3_y", 32'(cursor_y), 475);
`endif
        // 4: simultaneous key and mouse requests alternate, key first
        key_left = 1;
        for (int p = 0; p < 2; p++) begin
            for (int g = 0; g < 20 && !(m_pend && m_busy == 0); g++) cyc();
            send(3, -3, w);
            chk("t4_mouse_wait", w, 4);
        end
        key_left = 0;
        repeat (6) cyc();
        commit_now();
        // 5: frame_start during APPLY commits the fresh value
        do_reset();
        send(5, 0, w);
        chk("t5_wait", w, 1);
        commit_now();
        cyc();
        chk("t5_x", 32'(cursor_x), 325);
        chk("t5_pulse", 32'(pos_update), 1);
        // 6: reset mid-APPLY discards the delta
        do_reset();
        send(50, 0, w);
        reset = 0; mouse_valid = 1; mouse_dx = 9'd7;
        cyc();
        chk("t6_ready_rst0", 32'(dut_took), 0);
        cyc();
        chk("t6_ready_rst1", 32'(dut_took), 0);
        reset = 1; mouse_valid = 0;
        cyc();
        commit_now();
        chk("t6_x", 32'(cursor_x), 320);
        chk("t6_y", 32'(cursor_y), 240);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (!mouse_valid && $urandom_range(3) == 0) begin
                mouse_valid = 1; mouse_dx = 9'($urandom); mouse_dy = 9'($urandom);
            end
            frame_start = $urandom_range(5) == 0;
            if ($urandom_range(9) == 0) {key_up, key_down, key_left, key_right} = 4'($urandom);
            reset = $urandom_range(199) != 0;
            cyc();
            if (dut_took) mouse_valid = 0;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
